// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the IF/MEM memory arbiter.
// State encoding, requester IDs and the default watchdog limit.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        IF_BUSY = 2'd1,
        DM_BUSY = 2'd2
    } arbState_t;

    localparam logic REQ_ID_IF = 1'b0;
    localparam logic REQ_ID_DM = 1'b1;

    localparam int DEFAULT_TIMEOUT_CYCLES = 255;

    function automatic logic ownerOf(arbState_t s);
        return (s == DM_BUSY) ? REQ_ID_DM : REQ_ID_IF;
    endfunction

endpackage

// File: rtl/mem_arb_wdog.sv
// Memory wait watchdog: counts busy cycles without mem_ready and flags expiry.
// Expiry is combinational on the TIMEOUT_CYCLES-th wait cycle; the counter clears on completion or idle.
module mem_arb_wdog
    import mem_arb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic busy,
    input  logic ready,
    output logic expired
);

    localparam int W = $clog2(TIMEOUT_CYCLES + 1);

    logic [W-1:0] waitCnt;

    assign expired = busy & ~ready & (waitCnt == W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            waitCnt <= '0;
        end else if (!busy || ready || expired) begin
            waitCnt <= '0;
        end else begin
            waitCnt <= waitCnt + 1'b1;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates fetch and MEM-stage accesses onto one single-port memory, data side first.
// mem_req one cycle after grant, *_valid one cycle after mem_ready; StallF/StallM hold requesters. Watchdog: MEM_ARB_TIMEOUT_EN.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    input  logic        if_abort,
    output logic [31:0] if_rdata,
    output logic        if_valid,
    input  logic        dm_req,
    input  logic        dm_we,
    input  logic [3:0]  dm_wstrb,
    input  logic [31:0] dm_addr,
    input  logic [31:0] dm_wdata,
    output logic [31:0] dm_rdata,
    output logic        dm_valid,
    output logic        mem_req,
    output logic        mem_we,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready,
    output logic        StallF,
    output logic        StallM,
    output logic        bus_err
);

    arbState_t   state, stateNxt;
    logic        dmGrant, ifGrant, busy, done, timedOut, abortSeen;
    logic [31:0] rdataSel;

    // A requester still holds its request during its own valid cycle; mask it so it is not re-granted.
    assign dmGrant  = dm_req & ~dm_valid;
    assign ifGrant  = if_req & ~if_valid & ~if_abort;
    assign busy     = (state != IDLE);
    assign done     = busy & (mem_ready | timedOut);
    assign rdataSel = mem_ready ? mem_rdata : '0;

    assign StallM = dm_req & ~dm_valid;
    assign StallF = (if_req & ~if_valid & ~if_abort) | StallM;

`ifdef MEM_ARB_TIMEOUT_EN
    mem_arb_wdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) uWdog (
        .clk     (clk),
        .rst_n   (rst_n),
        .busy    (busy),
        .ready   (mem_ready),
        .expired (timedOut)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus_err <= 1'b0;
        end else if (timedOut) begin
            bus_err <= 1'b1;
        end
    end
`else
    // Without the watchdog the limit has no effect; this folds to a constant 0.
    assign timedOut = (TIMEOUT_CYCLES < 0);
    assign bus_err  = 1'b0;
`endif

    always_comb begin
        stateNxt = state;
        case (state)
            IDLE: begin
                if (dmGrant) begin
                    stateNxt = DM_BUSY;
                end else if (ifGrant) begin
                    stateNxt = IF_BUSY;
                end
            end
            IF_BUSY, DM_BUSY: begin
                if (mem_ready || timedOut) begin
                    stateNxt = IDLE;
                end
            end
            default: stateNxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_wstrb <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            if_valid  <= 1'b0;
            dm_valid  <= 1'b0;
            if_rdata  <= '0;
            dm_rdata  <= '0;
            abortSeen <= 1'b0;
        end else begin
            state    <= stateNxt;
            if_valid <= 1'b0;
            dm_valid <= 1'b0;
            if (state == IDLE) begin
                if (dmGrant) begin
                    mem_req   <= 1'b1;
                    mem_we    <= dm_we;
                    mem_wstrb <= dm_wstrb;
                    mem_addr  <= dm_addr;
                    mem_wdata <= dm_wdata;
                end else if (ifGrant) begin
                    mem_req   <= 1'b1;
                    mem_we    <= 1'b0;
                    mem_wstrb <= '0;
                    mem_addr  <= if_addr;
                    mem_wdata <= '0;
                    abortSeen <= 1'b0;
                end
            end else if (done) begin
                mem_req <= 1'b0;
                if (ownerOf(state) == REQ_ID_DM) begin
                    dm_valid <= 1'b1;
                    dm_rdata <= rdataSel;
                end else if (!(abortSeen || if_abort)) begin
                    // A squashed fetch still finishes on the bus but is never delivered.
                    if_valid <= 1'b1;
                    if_rdata <= rdataSel;
                end
            end else if (state == IF_BUSY && if_abort) begin
                abortSeen <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized bench for mem_arbiter: transaction-level model of grant order, latency and delivery.
// A behavioural memory logs every bus transaction; expectations come from that log and the request set.
module tb_mem_arbiter;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  wstrb;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          startCyc;
        int          readyCyc;
    } memRec_t;

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int LONG_WAIT = 3;
`else
    localparam int LONG_WAIT = 5;
`endif

    logic        clk, rst_n;
    logic        if_req, if_abort, if_valid;
    logic [31:0] if_addr, if_rdata;
    logic        dm_req, dm_we, dm_valid;
    logic [3:0]  dm_wstrb;
    logic [31:0] dm_addr, dm_wdata, dm_rdata;
    logic        mem_req, mem_we, mem_ready;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        StallF, StallM, bus_err;

    int          nChk = 0;
    int          nPass = 0;
    int          cyc = 0;
    memRec_t     memLog[$];
    memRec_t     cur;
    int          waitLeft;
    bit          inTxn;
    bit          hang = 0;
    int          fixWait = -1;
    bit          fixRd = 0;
    logic [31:0] fixRdata = '0;
    logic [31:0] lastIfData = '0;
    logic [31:0] lastDmData = '0;
    logic        expBusErr;

    mem_arbiter #(.TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_abort(if_abort),
        .if_rdata(if_rdata), .if_valid(if_valid),
        .dm_req(dm_req), .dm_we(dm_we), .dm_wstrb(dm_wstrb), .dm_addr(dm_addr),
        .dm_wdata(dm_wdata), .dm_rdata(dm_rdata), .dm_valid(dm_valid),
        .mem_req(mem_req), .mem_we(mem_we), .mem_wstrb(mem_wstrb), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .StallF(StallF), .StallM(StallM), .bus_err(bus_err)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [95:0] got, input logic [95:0] exp);
        nChk++;
        if (got === exp) nPass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    endtask

    // Behavioural memory: random wait states, stray ready pulses while idle, hold-stability checks.
    initial begin
        mem_ready = 0;
        mem_rdata = '0;
        inTxn = 0;
        forever begin
            @(negedge clk);
            mem_ready = 0;
            if (!rst_n || !mem_req) begin
                inTxn = 0;
                if (rst_n && $urandom_range(0, 5) == 0) begin
                    mem_ready = 1;
                    mem_rdata = $urandom;
                end
            end else begin
                if (!inTxn) begin
                    inTxn = 1;
                    cur.addr = mem_addr;
                    cur.we = mem_we;
                    cur.wstrb = mem_wstrb;
                    cur.wdata = mem_wdata;
                    cur.startCyc = cyc;
                    waitLeft = (fixWait >= 0) ? fixWait : int'($urandom_range(0, 3));
                end else begin
                    chk("mem_hold", 96'({mem_addr, mem_we, mem_wstrb, mem_wdata}),
                        96'({cur.addr, cur.we, cur.wstrb, cur.wdata}));
                end
                if (!hang) begin
                    if (waitLeft == 0) begin
                        mem_ready = 1;
                        mem_rdata = fixRd ? fixRdata : $urandom;
                        cur.rdata = mem_rdata;
                        cur.readyCyc = cyc;
                        memLog.push_back(cur);
                        inTxn = 0;
                    end else begin
                        waitLeft--;
                    end
                end
            end
        end
    end

    task automatic scenario(input bit doIf, input bit doDm, input int abortAt,
                            input logic [31:0] ifA, input logic [31:0] dmA, input logic we,
                            input logic [3:0] strb, input logic [31:0] wd);
        int base, reqCyc, ifIdx, nRec;
        bit ifDone, dmDone, dropIf, dropDm, aborted, finished, expDmV, expIfV;
        memRec_t r;
        base = memLog.size();
        nRec = int'(doIf) + int'(doDm);
        ifIdx = base + int'(doDm);
        @(negedge clk); #1;
        if_req = doIf; if_addr = ifA; if_abort = 0;
        dm_req = doDm; dm_addr = dmA; dm_we = we; dm_wstrb = strb; dm_wdata = wd;
        reqCyc = cyc;
        ifDone = !doIf; dmDone = !doDm; dropIf = 0; dropDm = 0; aborted = 0; finished = 0;
        for (int k = 0; k < 100; k++) begin
            if (k > 0) begin
                @(negedge clk); #1;
                if (dropIf) begin if_req = 0; if_abort = 0; dropIf = 0; end
                if (dropDm) begin dm_req = 0; dropDm = 0; end
            end
            if (doIf && !ifDone && k == abortAt &&
                !(memLog.size() > ifIdx && memLog[ifIdx].readyCyc < cyc)) begin
                if_abort = 1; aborted = 1; ifDone = 1; dropIf = 1;
            end
            #1;
            expDmV = doDm && memLog.size() > base && memLog[base].readyCyc == cyc - 1;
            expIfV = doIf && !aborted && memLog.size() > ifIdx && memLog[ifIdx].readyCyc == cyc - 1;
            chk("dm_valid", 96'(dm_valid), 96'(expDmV));
            chk("if_valid", 96'(if_valid), 96'(expIfV));
            if (expDmV) begin
                chk("dm_rdata", 96'(dm_rdata), 96'(memLog[base].rdata));
                lastDmData = memLog[base].rdata;
                dmDone = 1; dropDm = 1;
            end
            if (expIfV) begin
                chk("if_rdata", 96'(if_rdata), 96'(memLog[ifIdx].rdata));
                lastIfData = memLog[ifIdx].rdata;
                ifDone = 1; dropIf = 1;
            end
            chk("StallM", 96'(StallM), 96'(dm_req && !expDmV));
            chk("StallF", 96'(StallF), 96'((if_req && !expIfV && !if_abort) || (dm_req && !expDmV)));
            if (ifDone && dmDone && memLog.size() >= base + nRec &&
                memLog[base + nRec - 1].readyCyc < cyc) begin
                finished = 1;
                break;
            end
        end
        if (!finished) chk("txn_timeout", 96'(0), 96'(1));
        if (doDm && memLog.size() > base) begin
            r = memLog[base];
            chk("dm_bus_fields", 96'({r.addr, r.we, r.wstrb, r.wdata}), 96'({dmA, we, strb, wd}));
            chk("dm_start", 96'(r.startCyc), 96'(reqCyc + 1));
        end
        if (doIf && memLog.size() > ifIdx) begin
            r = memLog[ifIdx];
            chk("if_bus_fields", 96'({r.addr, r.we, r.wstrb}), 96'({ifA, 1'b0, 4'h0}));
            chk("if_start", 96'(r.startCyc), 96'(doDm ? memLog[base].readyCyc + 2 : reqCyc + 1));
        end
        @(negedge clk); #1;
        if_req = 0; dm_req = 0; if_abort = 0;
        #1;
        chk("idle_after", 96'({mem_req, if_valid, dm_valid}), 96'(0));
        chk("if_rdata_hold", 96'(if_rdata), 96'(lastIfData));
        chk("dm_rdata_hold", 96'(dm_rdata), 96'(lastDmData));
    endtask

    initial begin
        #500000;
        $display("FAIL sim_timeout: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        int kind, reqCyc;
        bit expV;
        rst_n = 0;
        if_req = 0; if_addr = '0; if_abort = 0;
        dm_req = 0; dm_we = 0; dm_wstrb = '0; dm_addr = '0; dm_wdata = '0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_mem_ctrl", 96'({mem_req, mem_we, mem_wstrb}), 96'(0));
        chk("rst_mem_addr", 96'(mem_addr), 96'(0));
        chk("rst_mem_wdata", 96'(mem_wdata), 96'(0));
        chk("rst_valids", 96'({if_valid, dm_valid, bus_err}), 96'(0));
        chk("rst_rdata", 96'({if_rdata, dm_rdata}), 96'(0));
        @(negedge clk);
        rst_n = 1;

        // Single fetch, zero wait states.
        fixWait = 0; fixRd = 1; fixRdata = 32'h0050_0093;
        scenario(1, 0, -1, 32'h100, '0, 0, '0, '0);
        chk("fetch_0x100_data", 96'(if_rdata), 96'(32'h0050_0093));
        fixRd = 0;

        // Simultaneous requests: data write wins, fetch follows.
        fixWait = -1;
        scenario(1, 1, -1, 32'h200, 32'h2000, 1, 4'hF, 32'hDEAD_BEEF);

        // Squashed fetch completing on the bus.
        fixWait = 2;
        scenario(1, 0, 2, 32'h104, '0, 0, '0, '0);

        // Load with a long wait.
        fixWait = LONG_WAIT;
        scenario(0, 1, -1, '0, 32'h3000, 0, 4'h0, '0);
        fixWait = -1;

        for (int i = 0; i < 40; i++) begin
            kind = int'($urandom_range(0, 3));
            case (kind)
                0: scenario(1, 0, -1, $urandom, $urandom, 1'($urandom_range(0, 1)),
                            4'($urandom_range(0, 15)), $urandom);
                1: scenario(0, 1, -1, $urandom, $urandom, 1'($urandom_range(0, 1)),
                            4'($urandom_range(0, 15)), $urandom);
                2: scenario(1, 1, -1, $urandom, $urandom, 1'($urandom_range(0, 1)),
                            4'($urandom_range(0, 15)), $urandom);
                default: scenario(1, 0, int'($urandom_range(1, 4)), $urandom, $urandom, 1'b0,
                                  4'h0, $urandom);
            endcase
        end

`ifdef MEM_ARB_TIMEOUT_EN
        hang = 1;
        @(negedge clk); #1;
        dm_req = 1; dm_we = 0; dm_addr = 32'h4000;
        reqCyc = cyc;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk); #1;
            expV = (cyc == reqCyc + 5);
            chk("to_dm_valid", 96'(dm_valid), 96'(expV));
            chk("to_mem_req", 96'(mem_req), 96'(cyc <= reqCyc + 4));
            chk("to_bus_err", 96'(bus_err), 96'(cyc >= reqCyc + 5));
            if (expV) begin
                chk("to_rdata", 96'(dm_rdata), 96'(0));
                dm_req = 0;
            end
        end
        hang = 0;
        lastDmData = '0;
        expBusErr = 1;
        scenario(1, 0, -1, 32'h500, '0, 0, '0, '0);
        chk("bus_err_sticky", 96'(bus_err), 96'(1));
`else
        hang = 1;
        @(negedge clk); #1;
        dm_req = 1; dm_we = 0; dm_addr = 32'h4000;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk); #1;
            chk("hang_no_valid", 96'(dm_valid), 96'(0));
            chk("hang_mem_req", 96'(mem_req), 96'(1));
            chk("hang_bus_err", 96'(bus_err), 96'(0));
        end
        expBusErr = 0;
`endif

        // Reset in the middle of a data transaction.
        hang = 1;
        @(negedge clk); #1;
        dm_req = 1; dm_we = 0; dm_addr = 32'h3000;
        repeat (3) begin
            @(negedge clk); #1;
        end
        chk("pre_rst_mem_req", 96'(mem_req), 96'(1));
        chk("pre_rst_bus_err", 96'(bus_err), 96'(expBusErr));
        chk("pre_rst_StallM", 96'(StallM), 96'(1));
        rst_n = 0;
        #1;
        chk("arst_mem_req", 96'({mem_req, mem_we, mem_wstrb}), 96'(0));
        chk("arst_mem_bus", 96'({mem_addr, mem_wdata}), 96'(0));
        chk("arst_flags", 96'({if_valid, dm_valid, bus_err}), 96'(0));
        chk("arst_rdata", 96'({if_rdata, dm_rdata}), 96'(0));
        @(negedge clk);
        dm_req = 0; hang = 0; rst_n = 1;
        lastIfData = '0; lastDmData = '0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk); #1;
            chk("post_rst_no_valid", 96'({dm_valid, if_valid}), 96'(0));
            chk("post_rst_mem_req", 96'(mem_req), 96'(0));
        end
        scenario(0, 1, -1, '0, 32'h3004, 1, 4'h3, 32'h1234_5678);

        $display("%0d/%0d checks passed", nPass, nChk);
        $finish;
    end

endmodule
